// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads words from instruction memory over
// a req/ack link and holds one word for the consumer behind a valid/ready pair.
module inst_fetch_unit #(
   parameter int unsigned            DATA_BUS_WIDTH = 36,
   parameter int unsigned            ADDR_WIDTH     = 16,
   parameter logic [ADDR_WIDTH-1:0]  PC_RESET       = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      fetch_en,
   output logic [ADDR_WIDTH-1:0]     imem_addr,
   output logic                      imem_req,
   input  logic                      imem_ack,
   input  logic [DATA_BUS_WIDTH-1:0] imem_rdata,
   output logic [DATA_BUS_WIDTH-1:0] mem_data,
   output logic                      inst_valid,
   input  logic                      inst_ready,
   input  logic                      redirect_en,
   input  logic [ADDR_WIDTH-1:0]     redirect_addr,
   output logic [ADDR_WIDTH-1:0]     pc
);

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]     redir_q, redir_d;
   logic [DATA_BUS_WIDTH-1:0] mem_data_q, mem_data_d;
   logic                      valid_q, valid_d;
   logic                      discard_q, discard_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= PC_RESET;
         redir_q    <= PC_RESET;
         mem_data_q <= '0;
         valid_q    <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redir_q    <= redir_d;
         mem_data_q <= mem_data_d;
         valid_q    <= valid_d;
         discard_q  <= discard_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redir_d    = redir_q;
      mem_data_d = mem_data_q;
      valid_d    = valid_q;
      discard_d  = discard_q;

      unique case (state_q)
         IDLE: begin
            if (redirect_en) begin
               pc_d = redirect_addr;
            end
            if (fetch_en) begin
               state_d = REQ;
            end
         end

         REQ: begin
            if (imem_ack) begin
               if (redirect_en) begin
                  pc_d      = redirect_addr;
                  discard_d = 1'b0;
                  state_d   = fetch_en ? REQ : IDLE;
               end else if (discard_q) begin
                  pc_d      = redir_q;
                  discard_d = 1'b0;
                  state_d   = fetch_en ? REQ : IDLE;
               end else begin
                  mem_data_d = imem_rdata;
                  valid_d    = 1'b1;
                  state_d    = HOLD;
               end
            end else if (redirect_en) begin
               // The request in flight cannot be aborted: remember the target
               // and throw the returning word away when it finally arrives.
               redir_d   = redirect_addr;
               discard_d = 1'b1;
            end
         end

         HOLD: begin
            if (redirect_en || inst_ready) begin
               valid_d = 1'b0;
               pc_d    = redirect_en ? redirect_addr : pc_q + PC_ONE;
               state_d = fetch_en ? REQ : IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign imem_req   = (state_q == REQ);
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign mem_data   = mem_data_q;
   assign inst_valid = valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: a variable-latency memory model plus a
// program-order reference that tracks which address the next delivered word must come from.
module tb_inst_fetch_unit;

   localparam int DW = 36;
   localparam int AW = 16;
   localparam logic [AW-1:0] PC_RST = 16'hFFFF;
   localparam int N_CYCLES = 3000;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_en;
   logic [AW-1:0] imem_addr;
   logic          imem_req;
   logic          imem_ack;
   logic [DW-1:0] imem_rdata;
   logic [DW-1:0] mem_data;
   logic          inst_valid;
   logic          inst_ready;
   logic          redirect_en;
   logic [AW-1:0] redirect_addr;
   logic [AW-1:0] pc;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   inst_fetch_unit #(
      .DATA_BUS_WIDTH (DW),
      .ADDR_WIDTH     (AW),
      .PC_RESET       (PC_RST)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .imem_addr     (imem_addr),
      .imem_req      (imem_req),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .mem_data      (mem_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .pc            (pc)
   );

   // Memory contents are a fixed function of the address.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {4'hA, a, a ^ 16'h5A5A};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference state: address of the next word the consumer should see.
   logic [AW-1:0] exp_next;
   logic          pend_redir;
   logic          exp_valid;
   logic          exp_drop;
   logic          req_active;
   logic [AW-1:0] req_addr;
   int            wait_left;
   int            delivered;
   logic          found;

   initial begin
      reset         = 1'b1;
      fetch_en      = 1'b0;
      imem_ack      = 1'b0;
      imem_rdata    = '0;
      inst_ready    = 1'b0;
      redirect_en   = 1'b0;
      redirect_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req",   64'(imem_req),   64'(0));
      check_eq("rst_valid", 64'(inst_valid), 64'(0));
      check_eq("rst_data",  64'(mem_data),   64'(0));
      check_eq("rst_pc",    64'(pc),         64'(PC_RST));

      reset      = 1'b0;
      fetch_en   = 1'b1;
      exp_next   = PC_RST;
      pend_redir = 1'b0;
      exp_valid  = 1'b0;
      exp_drop   = 1'b0;
      req_active = 1'b0;
      req_addr   = '0;
      wait_left  = 0;
      delivered  = 0;

      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(negedge clk);
         // Consequences of the previous edge
         if (exp_valid) begin
            check_eq("word_valid", 64'(inst_valid), 64'(1));
            check_eq("word_pc",    64'(pc),         64'(exp_next));
            check_eq("word_data",  64'(mem_data),   64'(mem_word(exp_next)));
         end
         if (exp_drop) check_eq("drop_valid", 64'(inst_valid), 64'(0));
         if (inst_valid) check_eq("no_req_in_hold", 64'(imem_req), 64'(0));
         if (!inst_valid && !imem_req && !pend_redir) check_eq("pc_idle", 64'(pc), 64'(exp_next));
         if (req_active) check_eq("addr_stable", 64'(imem_addr), 64'(req_addr));

         // Stimulus for the coming edge
         fetch_en      = ($urandom_range(0, 9) != 0);
         inst_ready    = ($urandom_range(0, 2) != 0);
         redirect_en   = (cyc > 20) && ($urandom_range(0, 9) == 0);
         redirect_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         if (imem_req) begin
            if (!req_active) begin
               req_active = 1'b1;
               req_addr   = imem_addr;
               wait_left  = int'($urandom_range(0, 3));
            end
            imem_ack = (wait_left == 0);
            if (!imem_ack) wait_left--;
            imem_rdata = imem_ack ? mem_word(imem_addr) : DW'({$urandom, $urandom});
         end else begin
            imem_ack   = ($urandom_range(0, 15) == 0);
            imem_rdata = DW'({$urandom, $urandom});
         end

         // Reference update for the coming edge
         exp_valid = 1'b0;
         exp_drop  = 1'b0;
         if (inst_valid) begin
            if (redirect_en || inst_ready) begin
               delivered++;
               exp_next = redirect_en ? redirect_addr : 16'(exp_next + 16'd1);
            end else begin
               exp_valid = 1'b1;
            end
         end else if (imem_req) begin
            if (imem_ack) begin
               if (pend_redir || redirect_en) begin
                  exp_drop = 1'b1;
                  if (redirect_en) exp_next = redirect_addr;
               end else begin
                  check_eq("fetch_addr", 64'(imem_addr), 64'(exp_next));
                  exp_valid = 1'b1;
               end
               pend_redir = 1'b0;
               req_active = 1'b0;
            end else if (redirect_en) begin
               pend_redir = 1'b1;
               exp_next   = redirect_addr;
            end
         end else if (redirect_en) begin
            exp_next = redirect_addr;
         end
      end
      check_eq("progress", 64'(delivered > 100), 64'(1));

      // Reset in the middle of an outstanding request; the late ack must be ignored.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (imem_req) begin
            found = 1'b1;
         end else begin
            fetch_en    = 1'b1;
            inst_ready  = 1'b1;
            redirect_en = 1'b0;
            imem_ack    = 1'b0;
         end
      end
      check_eq("reach_req", 64'(found), 64'(1));
      imem_ack    = 1'b0;
      redirect_en = 1'b0;
      reset       = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_req",   64'(imem_req),   64'(0));
      check_eq("mid_rst_valid", 64'(inst_valid), 64'(0));
      check_eq("mid_rst_pc",    64'(pc),         64'(PC_RST));
      reset      = 1'b0;
      fetch_en   = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = mem_word(16'h1234);
      @(negedge clk);
      check_eq("late_ack_valid", 64'(inst_valid), 64'(0));
      check_eq("late_ack_req",   64'(imem_req),   64'(0));
      check_eq("late_ack_pc",    64'(pc),         64'(PC_RST));
      imem_ack = 1'b0;
      fetch_en = 1'b1;
      @(negedge clk);
      check_eq("refetch_req",  64'(imem_req),  64'(1));
      check_eq("refetch_addr", 64'(imem_addr), 64'(PC_RST));
      imem_ack   = 1'b1;
      imem_rdata = mem_word(PC_RST);
      inst_ready = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      check_eq("refetch_valid", 64'(inst_valid), 64'(1));
      check_eq("refetch_data",  64'(mem_data),   64'(mem_word(PC_RST)));
      @(negedge clk);
      check_eq("wrap_addr", 64'(imem_addr), 64'(16'h0000));
      check_eq("wrap_req",  64'(imem_req),  64'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
